// File: rtl/pong_pkg.sv
// Shared definitions for the VGA pong pipeline: screen geometry, coordinate
// width and the state encodings used by the sprite scan FSMs.
package pong_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    // Wide enough to address every visible pixel on either axis.
    localparam int COORD_W = $clog2((H_VISIBLE > V_VISIBLE) ? H_VISIBLE : V_VISIBLE);

    typedef enum logic [1:0] {
        V_IDLE   = 2'd0,
        V_ACTIVE = 2'd1,
        V_DONE   = 2'd2
    } v_state_e;

    typedef enum logic {
        H_IDLE   = 1'b0,
        H_ACTIVE = 1'b1
    } h_state_e;

endpackage

// File: rtl/span_counter.sv
// One axis of a sprite footprint: detects the start position (clipping an
// off-screen origin into a start offset) and holds the index inside the span.
module span_counter
    import pong_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int XW = COORD_W,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] pos,
    input  logic [XW:0]   org,
    input  logic          load,
    input  logic          inc,
    input  logic          abort,
    output logic          start_hit,
    output logic          last,
    output logic [IW-1:0] idx
);

    localparam logic [XW:0] SPAN = (XW + 1)'(N);

    logic          org_neg;
    logic [XW:0]   skip;
    logic [IW-1:0] idx_d;
    logic [IW-1:0] idx_q;

    always_comb begin
        org_neg = org[XW];
        // An origin left of/above the screen enters at coordinate 0, already
        // skip pixels into the sprite; a skip of N or more leaves nothing visible.
        skip      = org_neg ? -org : '0;
        start_hit = org_neg ? ((pos == '0) && (skip < SPAN))
                            : ({1'b0, pos} == org);
        last      = (idx_q == IW'(N - 1));

        idx_d = idx_q;
        if (load) begin
            idx_d = skip[IW-1:0];
        end else if (abort) begin
            idx_d = '0;
        end else if (inc && !last) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/sprite_scan.sv
// Rectangular sprite scan generator: latches the sprite origin once per frame
// and reports, one clock late, whether each raster pixel lies inside it.
module sprite_scan
    import pong_pkg::*;
#(
    parameter  int XW    = COORD_W,
    parameter  int SPR_W = 8,
    parameter  int SPR_H = 8,
    localparam int CW    = $clog2(SPR_W),
    localparam int RW    = $clog2(SPR_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic [XW-1:0] screenx,
    input  logic [XW-1:0] screeny,
    input  logic [XW-1:0] pos_x,
    input  logic [XW-1:0] pos_y,
    input  logic          enable,
    output logic          scan,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row
);

    localparam logic [XW:0] HALF_W = (XW + 1)'(SPR_W / 2);
    localparam logic [XW:0] HALF_H = (XW + 1)'(SPR_H / 2);

    logic [XW:0] org_x_d, org_x_q;
    logic [XW:0] org_y_d, org_y_q;
    logic        en_d, en_q;

    v_state_e v_state_d, v_state_q, v_from;
    h_state_e h_state_d, h_state_q, h_from;
    logic     scan_d, scan_q;

    logic          line_start;
    logic          row_load, row_inc, row_hit, row_last;
    logic          col_load, col_inc, col_hit, col_last;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;

    // The _d values double as this cycle's effective shadow, so a frame_start
    // cycle already scans against the origin it is latching.
    always_comb begin : shadow_next
        org_x_d = org_x_q;
        org_y_d = org_y_q;
        en_d    = en_q;
        if (frame_start) begin
            org_x_d = {1'b0, pos_x} - HALF_W;
            org_y_d = {1'b0, pos_y} - HALF_H;
            en_d    = enable;
        end
    end

    assign line_start = (screenx == '0);

    always_comb begin : v_fsm_next
        v_state_d = v_state_q;
        row_load  = 1'b0;
        row_inc   = 1'b0;
        v_from    = frame_start ? V_IDLE : v_state_q;
        if (frame_start) begin
            v_state_d = V_IDLE;
        end
        if (line_start) begin
            case (v_from)
                V_IDLE: begin
                    if (en_d && row_hit) begin
                        v_state_d = V_ACTIVE;
                        row_load  = 1'b1;
                    end
                end
                V_ACTIVE: begin
                    if (row_last) begin
                        v_state_d = V_DONE;
                    end else begin
                        row_inc = 1'b1;
                    end
                end
                default: v_state_d = v_from;
            endcase
        end
    end

    // A line start ends any run still open from the previous line (right clip)
    // and is then evaluated as a fresh entry point.
    always_comb begin : h_fsm_next
        h_state_d = H_IDLE;
        col_load  = 1'b0;
        col_inc   = 1'b0;
        h_from    = line_start ? H_IDLE : h_state_q;
        if (v_state_d == V_ACTIVE) begin
            case (h_from)
                H_IDLE: begin
                    if (col_hit) begin
                        h_state_d = H_ACTIVE;
                        col_load  = 1'b1;
                    end
                end
                H_ACTIVE: begin
                    if (!col_last) begin
                        h_state_d = H_ACTIVE;
                        col_inc   = 1'b1;
                    end
                end
                default: h_state_d = H_IDLE;
            endcase
        end
        scan_d = (h_state_d == H_ACTIVE);
    end

    span_counter #(
        .N  (SPR_H),
        .XW (XW)
    ) u_row (
        .clk       (clk),
        .reset     (reset),
        .pos       (screeny),
        .org       (org_y_d),
        .load      (row_load),
        .inc       (row_inc),
        .abort     (frame_start),
        .start_hit (row_hit),
        .last      (row_last),
        .idx       (row_idx)
    );

    span_counter #(
        .N  (SPR_W),
        .XW (XW)
    ) u_col (
        .clk       (clk),
        .reset     (reset),
        .pos       (screenx),
        .org       (org_x_d),
        .load      (col_load),
        .inc       (col_inc),
        .abort     (line_start),
        .start_hit (col_hit),
        .last      (col_last),
        .idx       (col_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            org_x_q   <= '0;
            org_y_q   <= '0;
            en_q      <= 1'b0;
            v_state_q <= V_IDLE;
            h_state_q <= H_IDLE;
            scan_q    <= 1'b0;
        end else begin
            org_x_q   <= org_x_d;
            org_y_q   <= org_y_d;
            en_q      <= en_d;
            v_state_q <= v_state_d;
            h_state_q <= h_state_d;
            scan_q    <= scan_d;
        end
    end

    assign scan = scan_q;
    assign col  = col_idx;
    assign row  = row_idx;

endmodule

// File: tb/tb_sprite_scan.sv
// Bench for sprite_scan: drives raster frames and compares every output cycle
// against a per-frame rectangle model of the sprite footprint.
module tb_sprite_scan;

    localparam int XW    = 10;
    localparam int SPR_W = 8;
    localparam int SPR_H = 8;
    localparam int CW    = $clog2(SPR_W);
    localparam int RW    = $clog2(SPR_H);

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [XW-1:0] screenx, screeny, pos_x, pos_y;
    logic          enable;
    logic          scan;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always #5 clk = ~clk;

    sprite_scan #(
        .XW    (XW),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .screenx     (screenx),
        .screeny     (screeny),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .enable      (enable),
        .scan        (scan),
        .col         (col),
        .row         (row)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: sprite rectangle as seen by the current frame.
    int fox, foy;
    bit fen;

    // Expectation for the pixel driven in the previous cycle.
    bit p_scan;
    int p_col, p_row, p_frame;

    int frame_no;
    int hits[64];
    int want_hits[64];

    // Optional mid-frame input change and mid-frame reset.
    int            ev_line  = -1;
    logic [XW-1:0] ev_px, ev_py;
    logic          ev_en;
    int            rst_line = -1;
    int            rst_x    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic check_prev();
        check("scan", 32'(scan), 32'(p_scan));
        if (p_scan) begin
            check("col", 32'(col), p_col);
            check("row", 32'(row), p_row);
        end
        if (scan === 1'b1) hits[p_frame]++;
    endtask

    task automatic check_frame_hits(input int k);
        if (k > 0 && want_hits[k] >= 0) check("frame_hits", hits[k], want_hits[k]);
    endtask

    task automatic drive(input int x, input int y, input bit fs);
        screenx     = XW'(x);
        screeny     = XW'(y);
        frame_start = fs;
        if (fs) begin
            fox = int'(pos_x) - SPR_W / 2;
            foy = int'(pos_y) - SPR_H / 2;
            fen = enable;
        end
        p_frame = frame_no;
        p_col   = x - fox;
        p_row   = y - foy;
        p_scan  = fen && p_col >= 0 && p_col < SPR_W && p_row >= 0 && p_row < SPR_H;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_scan", 32'(scan), 32'd0);
        check("rst_col", 32'(col), 32'd0);
        check("rst_row", 32'(row), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        fen   = 1'b0;
    endtask

    task automatic run_frame(input int lw, input int nl, input int want);
        frame_no++;
        want_hits[frame_no] = want;
        hits[frame_no]      = 0;
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < lw; x++) begin
                @(negedge clk);
                check_prev();
                if (x == 0 && y == 0) check_frame_hits(frame_no - 1);
                if (y == ev_line && x == 0) begin
                    pos_x  = ev_px;
                    pos_y  = ev_py;
                    enable = ev_en;
                end
                if (y == rst_line && x == rst_x) do_reset();
                drive(x, y, (x == 0 && y == 0));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        screenx     = XW'(5);
        screeny     = '0;
        pos_x       = '0;
        pos_y       = '0;
        enable      = 1'b0;
        fen         = 1'b0;
        fox         = 0;
        foy         = 0;
        p_scan      = 1'b0;
        p_col       = 0;
        p_row       = 0;
        p_frame     = 0;
        frame_no    = 0;
        foreach (hits[i]) begin
            hits[i]      = 0;
            want_hits[i] = -1;
        end

        repeat (3) @(negedge clk);
        check("reset_scan", 32'(scan), 32'd0);
        check("reset_col", 32'(col), 32'd0);
        check("reset_row", 32'(row), 32'd0);
        reset = 1'b0;

        // Raster running with a visible-looking sprite but no frame_start yet.
        pos_x  = XW'(4);
        pos_y  = XW'(4);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_prev();
            drive(i, 0, 1'b0);
        end

        // Centre placement: 8x8 block at x 96..103, y 46..53.
        pos_x = XW'(100); pos_y = XW'(50);
        run_frame(128, 56, 64);

        // Left/top clip: org (-2,-3) -> cols 2..7 on rows 3..7.
        pos_x = XW'(2); pos_y = XW'(1);
        run_frame(16, 10, 30);

        // Right clip: x 633..639 on rows from y 0.
        pos_x = XW'(637); pos_y = XW'(4);
        run_frame(640, 10, 56);

        // Position change mid-frame applies from the next frame only.
        pos_x = XW'(40); pos_y = XW'(50);
        ev_line = 20; ev_px = XW'(40); ev_py = XW'(200); ev_en = 1'b1;
        run_frame(64, 56, 64);
        ev_line = -1;
        run_frame(48, 206, 64);

        // Disabled at frame_start; enable rising mid-frame is ignored.
        enable = 1'b0; pos_x = XW'(20); pos_y = XW'(10);
        ev_line = 5; ev_px = XW'(20); ev_py = XW'(10); ev_en = 1'b1;
        run_frame(40, 24, 0);
        ev_line = -1;

        // Asynchronous reset while drawing; resumes at the following frame.
        enable = 1'b1; pos_x = XW'(10); pos_y = XW'(10);
        rst_line = 9; rst_x = 12;
        run_frame(32, 20, 30);
        rst_line = -1;
        run_frame(32, 20, 64);

        // Bottom clip by an early frame_start, then a clean frame.
        pos_x = XW'(10); pos_y = XW'(17);
        run_frame(32, 16, 24);
        pos_y = XW'(4);
        run_frame(32, 16, 64);

        // Random placements, sizes, enables and mid-frame disturbances.
        for (int f = 0; f < 16; f++) begin
            int lw, nl;
            lw      = $urandom_range(16, 64);
            nl      = $urandom_range(8, 32);
            pos_x   = XW'($urandom_range(0, lw + 6));
            pos_y   = XW'($urandom_range(0, nl + 6));
            enable  = ($urandom_range(0, 3) != 0);
            ev_line = $urandom_range(1, nl - 1);
            ev_px   = XW'($urandom_range(0, lw));
            ev_py   = XW'($urandom_range(0, nl));
            ev_en   = ($urandom_range(0, 1) != 0);
            run_frame(lw, nl, -1);
        end
        ev_line = -1;

        @(negedge clk);
        check_prev();
        check_frame_hits(frame_no);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_scan.md
Name: sprite_scan

Overview:
- Parametrised scan generator for rectangular sprites (ball, bats, score digits) in the VGA pong pipeline.
- Compares the raster position against a sprite origin latched once per frame, then walks a column/row counter across the sprite footprint.
- Outputs a registered hit flag plus column/row indices, so a downstream bitmap ROM can shape the sprite.
- Handles left/top clipping (origin off-screen) and right/bottom clipping without wrap-around artefacts.

Parameters:
- XW, 10, width of the screen/position coordinates.
- SPR_W, 8, sprite width in pixels (2..256).
- SPR_H, 8, sprite height in lines (2..256).
- CW, $clog2(SPR_W), column index width (derived, not overridden).
- RW, $clog2(SPR_H), row index width (derived, not overridden).

Ports:
- clk, input, 1, master pixel clock.
- reset, input, 1, asynchronous active-high reset.
- frame_start, input, 1, one-cycle strobe at the first pixel of a frame; latches position/enable.
- screenx, input, XW, raster x; screenx==0 marks line start.
- screeny, input, XW, raster y.
- pos_x, input, XW, sprite centre x.
- pos_y, input, XW, sprite centre y.
- enable, input, 1, sprite visible in the next frame.
- scan, output, 1, registered: current pixel lies inside the sprite.
- col, output, CW, column index of the pixel inside the sprite; valid when scan=1.
- row, output, RW, row index of the pixel inside the sprite; valid when scan=1.

Behaviour:
- **Reset:** scan=0, col=0, row=0; both FSMs go to IDLE; shadow position=0, shadow enable=0. Reset is async assert and acts mid-frame; after release, nothing is drawn until the next frame_start.
- **Shadow latch:** on frame_start, org_x = pos_x − SPR_W/2 and org_y = pos_y − SPR_H/2 are computed signed in XW+1 bits and latched with enable. pos_* changes at any other time have no effect (no tearing).
- **Vertical FSM (V_IDLE, V_ACTIVE, V_DONE)**, evaluated only on cycles with screenx==0:
  - frame_start forces V_IDLE. frame_start coincides with screenx==0; the freshly latched origin is used in that same cycle.
  - V_IDLE→V_ACTIVE when shadow enable=1 and either screeny==org_y (org_y≥0), or org_y<0 and screeny==0. Row start is 0 or −org_y respectively.
  - In V_ACTIVE, row increments on each subsequent line start; after row SPR_H−1 the FSM goes to V_DONE.
  - A row start of −org_y ≥ SPR_H means the sprite is fully off-screen: stay in V_IDLE.
  - V_DONE holds until frame_start. If screeny wraps before SPR_H rows, the next frame_start truncates the sprite (bottom clip).
- **Horizontal FSM (H_IDLE, H_ACTIVE):**
  - Runs only while V_ACTIVE.
  - H_IDLE→H_ACTIVE when screenx==org_x (org_x≥0), or at screenx==0 when org_x<0, with col start −org_x. A col start ≥ SPR_W means no entry.
  - col increments every clk; after col SPR_W−1 the FSM returns to H_IDLE.
  - screenx==0 while H_ACTIVE aborts the run to H_IDLE (right clip), then re-evaluates entry in the same cycle.
- **Latency:** scan/col/row are registered, one clk after the screenx/screeny they describe.
- **Indexing:** the first visible pixel has col=0,row=0 unless clipped. All counter arithmetic is unsigned, with no wrap beyond SPR_W−1/SPR_H−1.

Decomposition:
- Shared package `pong_pkg`:
  - screen size constants (H_VISIBLE=640, V_VISIBLE=480);
  - the XW coordinate width;
  - state encodings for the scan FSMs.
- One natural sub-module: `span_counter`, instantiated twice (horizontal, vertical). It provides start-match, clipped start offset, counting to N−1 and an abort input.

Test Plan:
- SPR_W=SPR_H=8, pos=(100,50), enable=1, frame_start → scan=1 for screenx 96..103 on screeny 46..53, reported one clk later; col 0..7, row 0..7; 64 hit pixels total.
- pos_x=2 (org_x=−2) → on each active line scan asserts one clk after screenx=0, for screenx 0..5 with col 2..7; pos_y=1 → rows start at 3 on screeny 0.
- pos_x=637 → scan for screenx 633..639 (col 0..6), aborted at screenx=0; no hit on the next line's start pixels beyond the row pattern.
- pos_y changed from 50 to 200 mid-frame → current frame still draws at lines 46..53; next frame draws at 196..203.
- enable=0 at frame_start → scan stays 0 the whole frame, even if enable rises mid-frame.
- reset pulsed asynchronously while scan=1 → scan/col/row go to 0 immediately; no hit until after the next frame_start.
